data_memory_arbiter: RTL

- Two-requester controller that shares the single-ported data memory between port 0 (CPU load/store stage) and port 1 (debug/DMA loader).
- Arbitrates round-robin, latches the winning request, drives the memory's address, write-data, write-enable and read-enable lines for a fixed access latency, then returns read data with a one-cycle acknowledge.
- Sits between the requesters and the data memory.
- Memory side is purely combinational from registered state.

---
 rtl/data_memory_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_arbiter
//  Description : Round-robin arbiter sharing one single-ported data memory
//                between a CPU load/store port (0) and a debug/DMA port (1).
//                The winning request is latched, presented to the memory for
//                LAT cycles, then acknowledged with a one-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2     // legal range 1..15
) (
    input  logic              clk_i,
    input  logic              rst_i,       // asynchronous, active low

    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              ack0_o,
    output logic [DATA_W-1:0] rdata0_o,

    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata1_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Counter value on the final access cycle; 4 bits covers LAT up to 15.
    localparam logic [3:0] C_CNT_LAST = 4'(LAT - 1);

    state_t              state_q, state_d;
    logic                ptr_q,   ptr_d;     // preferred port when both request
    logic                gnt_q,   gnt_d;     // port owning the current transfer
    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          cnt_q,   cnt_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic                w_grant;

    // Pick the winner: a lone requester wins outright, a tie goes to the pointer.
    always_comb begin
        w_grant = 1'b0;
        if (req0_i && req1_i) begin
            w_grant = ptr_q;
        end else if (req1_i) begin
            w_grant = 1'b1;
        end
    end

    // Next-state logic: latch in IDLE, count in ACCESS, rotate priority in DONE.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    gnt_d   = w_grant;
                    we_d    = w_grant ? we1_i    : we0_i;
                    addr_d  = w_grant ? addr1_i  : addr0_i;
                    wdata_d = w_grant ? wdata1_i : wdata0_i;
                    cnt_d   = 4'd0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == C_CNT_LAST) begin
                    // Read data is sampled on the last strobed edge.
                    if (!we_q) begin
                        if (gnt_q) begin
                            rdata1_d = mem_rdata_i;
                        end else begin
                            rdata0_d = mem_rdata_i;
                        end
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Hand priority to the port that just lost.
                ptr_d   = ~gnt_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= 4'd0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Memory side and acknowledges are decoded purely from registered state.
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_write_o = (state_q == ST_ACCESS) &&  we_q;
    assign mem_read_o  = (state_q == ST_ACCESS) && !we_q;
    assign ack0_o      = (state_q == ST_DONE) && !gnt_q;
    assign ack1_o      = (state_q == ST_DONE) &&  gnt_q;
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
